// File: rtl/msrv32_load_unit_seq.sv
// Sequential load unit: word-aligned bus reads, optional two-beat split for boundary-crossing loads, byte align + extend.
// Latency: accept at N, dmreq at N+1, result at N+3 with zero bus wait; a split adds two cycles; a blocked crossing load answers at N+1.
// Backpressure: one load in flight (lu_ready_out low otherwise); dmaddr held until dmready. Macro MSRV32_MISALIGN_SPLIT_EN enables the split.
module msrv32_load_unit_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              lu_req_in,
  output logic              lu_ready_out,
  input  logic [ADDR_W-1:0] lu_addr_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic [TAG_W-1:0]  lu_tag_in,
  output logic              ms_riscv32_mp_dmreq_out,
  output logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
  input  logic              ms_riscv32_mp_dmready_in,
  input  logic              ms_riscv32_mp_dmvalid_in,
  input  logic [DATA_W-1:0] ms_riscv32_mp_dmdata_in,
  input  logic              ahb_resp_in,
  output logic              lu_valid_out,
  output logic [DATA_W-1:0] lu_output_out,
  output logic [TAG_W-1:0]  lu_tag_out,
  output logic              lu_error_out,
  output logic              lu_misaligned_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR0,
    S_DATA0,
`ifdef MSRV32_MISALIGN_SPLIT_EN
    S_ADDR1,
    S_DATA1,
`endif
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                err_q, err_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [TAG_W-1:0]    otag_q, otag_d;

  logic [OFF_W-1:0]    req_off;
  logic [1:0]          req_size;
  logic                req_uns;
  logic [1:0]          eff_size;
  logic [3:0]          size_bytes;
  logic                split;
  logic [2*DATA_W-1:0] sh;
  logic                fill;
  logic [DATA_W-1:0]   res;

  // While idle the request fields come straight from the port, afterwards from the latch.
  assign req_off  = (state_q == S_IDLE) ? lu_addr_in[OFF_W-1:0] : addr_q[OFF_W-1:0];
  assign req_size = (state_q == S_IDLE) ? load_size_in : size_q;
  assign req_uns  = (state_q == S_IDLE) ? load_unsigned_in : uns_q;

  // A doubleword on a 32-bit bus degrades to a word.
  assign eff_size = (DATA_W == 32 && req_size == 2'b11) ? 2'b10 : req_size;

  // Access size in bytes and whether the access crosses a bus word.
  always_comb begin
    size_bytes = 4'd1;
    case (eff_size)
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
    split = ({{(4-OFF_W){1'b0}}, req_off} + size_bytes) > 4'(BYTES);
  end

  // Align the captured beats, then sign- or zero-fill above the access width.
  always_comb begin
    sh   = {hi_d, lo_d} >> {req_off, 3'b000};
    fill = 1'b0;
    case (eff_size)
      2'b00:   fill = ~req_uns & sh[7];
      2'b01:   fill = ~req_uns & sh[15];
      2'b10:   fill = ~req_uns & sh[31];
      default: fill = 1'b0;
    endcase
    res = sh[DATA_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= 8 * int'(size_bytes)) res[i] = fill;
    end
  end

  // Next-state and holding-register update for the bus sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    tag_d   = tag_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (lu_req_in) begin
          addr_d = lu_addr_in;
          size_d = load_size_in;
          uns_d  = load_unsigned_in;
          tag_d  = lu_tag_in;
          lo_d   = '0;
          hi_d   = '0;
          err_d  = 1'b0;
          mis_d  = 1'b0;
`ifdef MSRV32_MISALIGN_SPLIT_EN
          state_d = S_ADDR0;
`else
          if (split) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ADDR0;
          end
`endif
        end
      end
      S_ADDR0: if (ms_riscv32_mp_dmready_in) state_d = S_DATA0;
      S_DATA0: begin
        if (ms_riscv32_mp_dmvalid_in) begin
          lo_d = ms_riscv32_mp_dmdata_in;
          if (ahb_resp_in) begin
            err_d   = 1'b1;
            state_d = S_RESP;
`ifdef MSRV32_MISALIGN_SPLIT_EN
          end else if (split) begin
            state_d = S_ADDR1;
`endif
          end else begin
            state_d = S_RESP;
          end
        end
      end
`ifdef MSRV32_MISALIGN_SPLIT_EN
      S_ADDR1: if (ms_riscv32_mp_dmready_in) state_d = S_DATA1;
      S_DATA1: begin
        if (ms_riscv32_mp_dmvalid_in) begin
          hi_d    = ms_riscv32_mp_dmdata_in;
          err_d   = ahb_resp_in;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result and tag are captured on entry to RESP and persist until the next one.
  always_comb begin
    out_d  = out_q;
    otag_d = otag_q;
    if (state_d == S_RESP) begin
      out_d  = (err_d || mis_d) ? '0 : res;
      otag_d = tag_d;
    end
  end

  // State and holding registers; reset abandons any access in flight.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      tag_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      out_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      tag_q   <= tag_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      out_q   <= out_d;
      otag_q  <= otag_d;
    end
  end

  assign lu_ready_out            = (state_q == S_IDLE);
  assign lu_valid_out            = (state_q == S_RESP);
  assign lu_output_out           = out_q;
  assign lu_tag_out              = otag_q;
  assign lu_error_out            = (state_q == S_RESP) && err_q;
  assign lu_misaligned_out       = (state_q == S_RESP) && mis_q;

`ifdef MSRV32_MISALIGN_SPLIT_EN
  assign ms_riscv32_mp_dmreq_out  = (state_q == S_ADDR0) || (state_q == S_ADDR1);
  assign ms_riscv32_mp_dmaddr_out = (state_q == S_ADDR0) ? (addr_q & ~ADDR_W'(BYTES - 1)) :
                                    (state_q == S_ADDR1) ? ((addr_q & ~ADDR_W'(BYTES - 1)) + ADDR_W'(BYTES)) :
                                    '0;
`else
  assign ms_riscv32_mp_dmreq_out  = (state_q == S_ADDR0);
  assign ms_riscv32_mp_dmaddr_out = (state_q == S_ADDR0) ? (addr_q & ~ADDR_W'(BYTES - 1)) : '0;
`endif

endmodule
